hps_gpio_pio: RTL and testbench



---
 rtl/hps_pio_pkg.sv | 25 ++
 rtl/hps_gpio_pio_if.sv | 28 ++
 rtl/hps_pio_sync.sv | 32 +++
 rtl/hps_gpio_pio.sv | 113 +++++++++++
 tb/tb_hps_gpio_pio.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hps_pio_pkg.sv
// ==========================================================================
// hps_pio_pkg : register map, edge modes and bus widths for hps_gpio_pio
// Rev 1.0
// ==========================================================================
`default_nettype none

package hps_pio_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

`default_nettype wire

// File: rtl/hps_gpio_pio_if.sv
// ==========================================================================
// hps_gpio_pio_if : Avalon-MM slave bus bundle for the GPIO block
// Rev 1.0
// ==========================================================================
`default_nettype none

interface hps_gpio_pio_if;
  import hps_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

`default_nettype wire

// File: rtl/hps_pio_sync.sv
// ==========================================================================
// hps_pio_sync : multi-stage synchroniser for asynchronous input pins
// Rev 1.0
// ==========================================================================
`default_nettype none

module hps_pio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hps_gpio_pio.sv
// ==========================================================================
// hps_gpio_pio : Avalon-MM GPIO with direction, set/clear, edge capture, IRQ
// Rev 1.0
// ==========================================================================
`default_nettype none

module hps_gpio_pio
  import hps_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  hps_gpio_pio_if.slave         bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic      [WIDTH-1:0] out_port,
  output logic      [WIDTH-1:0] oe_port,
  output logic                  irq
);

  logic [WIDTH-1:0] r_data_out, r_dir, r_mask, r_edge, r_prev;
  logic             r_irq, r_armed;
  logic [2:0]       r_arm_cnt;

  logic [WIDTH-1:0]  w_in_sync, w_wd, w_raw, w_det, w_clr;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd;

  hps_pio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_in_sync)
  );

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_wd  = bus.writedata[WIDTH-1:0];
  assign w_clr = (w_wr && bus.address == ADDR_EDGE) ? w_wd : '0;

  always_comb begin
    w_raw = w_in_sync & ~r_prev;
    case (EDGE_TYPE)
      EDGE_FALL: w_raw = ~w_in_sync & r_prev;
      EDGE_ANY:  w_raw = w_in_sync ^ r_prev;
      default:   w_raw = w_in_sync & ~r_prev;
    endcase
    w_det = r_armed ? (w_raw & ~r_dir) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE[WIDTH-1:0];
      r_dir      <= RESET_DIR[WIDTH-1:0];
      r_mask     <= '0;
    end else if (w_wr) begin
      case (bus.address)
        ADDR_DATA: r_data_out <= w_wd;
        ADDR_DIR:  r_dir      <= w_wd;
        ADDR_MASK: r_mask     <= w_wd;
        ADDR_SET:  r_data_out <= r_data_out | w_wd;
        ADDR_CLR:  r_data_out <= r_data_out & ~w_wd;
        default:   ;
      endcase
    end
  end

  // OR-ing the detection in after the clear lets a coincident edge win
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
      r_prev <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_det;
      r_prev <= w_in_sync;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  // Hold off capture until the synchroniser and prev flops carry real pin data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == 3'(SYNC_STAGES)) r_armed   <= 1'b1;
      else                              r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      ADDR_DATA: w_rd[WIDTH-1:0] = (r_data_out & r_dir) | (w_in_sync & ~r_dir);
      ADDR_DIR:  w_rd[WIDTH-1:0] = r_dir;
      ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge;
      default:   ;
    endcase
    bus.readdata = w_rd;
  end

  assign out_port = r_data_out;
  assign oe_port  = r_dir;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_hps_gpio_pio.sv
// ==========================================================================
// tb_hps_gpio_pio : directed self-checking bench for hps_gpio_pio
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_hps_gpio_pio;
  import hps_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_a, in_b, out_a, oe_a, out_b, oe_b;
  logic       irq_a, irq_b;
  int         checks = 0;
  int         errors = 0;

  hps_gpio_pio_if bus_a();
  hps_gpio_pio_if bus_b();

  always #5 clk = ~clk;

  hps_gpio_pio #(
    .WIDTH(8), .RESET_VALUE(32'hA5), .RESET_DIR(32'hFF),
    .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_a),
    .out_port(out_a), .oe_port(oe_a), .irq(irq_a)
  );

  hps_gpio_pio #(
    .WIDTH(8), .RESET_VALUE(32'h0), .RESET_DIR(32'h0),
    .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .in_port(in_b),
    .out_port(out_b), .oe_port(oe_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge
  task automatic wr_a(input logic [2:0] addr, input logic [31:0] data);
    bus_a.address    = addr;
    bus_a.writedata  = data;
    bus_a.chipselect = 1'b1;
    bus_a.write_n    = 1'b0;
    @(negedge clk);
    bus_a.chipselect = 1'b0;
    bus_a.write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input bit sel_b, input logic [2:0] addr,
                    input logic [31:0] exp);
    logic [31:0] v;
    if (sel_b) bus_b.address = addr;
    else       bus_a.address = addr;
    #1;
    v = sel_b ? bus_b.readdata : bus_a.readdata;
    chk(tag, v, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    in_a = 8'h00;
    in_b = 8'hFF;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    wait_n(3);

    chk("rst_out",  32'(out_a), 32'hA5);
    chk("rst_oe",   32'(oe_a),  32'hFF);
    chk("rst_irq",  32'(irq_a), 32'h0);
    rd ("rst_data", 1'b0, ADDR_DATA, 32'h0000_00A5);
    chk("rst_oe_b", 32'(oe_b),  32'h0);
    reset_n = 1'b1;
    wait_n(1);

    wr_a(ADDR_DATA, 32'h0F);
    chk("data_wr", 32'(out_a), 32'h0F);
    wr_a(ADDR_SET, 32'h30);
    chk("outset", 32'(out_a), 32'h3F);
    wr_a(ADDR_CLR, 32'h03);
    chk("outclr", 32'(out_a), 32'h3C);
    rd ("rd_set", 1'b0, ADDR_SET, 32'h0);
    rd ("rd_clr", 1'b0, ADDR_CLR, 32'h0);

    // B held its pins high through reset release: nothing may be captured
    wait_n(4);
    rd("b_arm_edge", 1'b1, ADDR_EDGE, 32'h0);
    rd("b_data",     1'b1, ADDR_DATA, 32'hFF);

    wr_a(ADDR_MASK, 32'h01);
    wr_a(ADDR_DIR,  32'h00);
    rd("rd_mask", 1'b0, ADDR_MASK, 32'h01);
    in_a = 8'h01;
    wait_n(1);
    rd ("sync_n1", 1'b0, ADDR_DATA, 32'h00);
    wait_n(1);
    rd ("sync_n2", 1'b0, ADDR_DATA, 32'h01);
    rd ("edge_n2", 1'b0, ADDR_EDGE, 32'h00);
    wait_n(1);
    rd ("edge_n3", 1'b0, ADDR_EDGE, 32'h01);
    chk("irq_n3",  32'(irq_a), 32'h0);
    wait_n(1);
    chk("irq_n4",  32'(irq_a), 32'h1);
    wr_a(ADDR_EDGE, 32'h01);
    rd ("w1c_edge", 1'b0, ADDR_EDGE, 32'h00);
    chk("w1c_irq_hold", 32'(irq_a), 32'h1);
    wait_n(1);
    chk("w1c_irq_drop", 32'(irq_a), 32'h0);

    in_a = 8'h00;
    wait_n(4);
    rd ("fall_ignored", 1'b0, ADDR_EDGE, 32'h00);
    in_a = 8'h01;
    wait_n(4);
    rd ("rise2_edge", 1'b0, ADDR_EDGE, 32'h01);
    chk("rise2_irq", 32'(irq_a), 32'h1);
    in_a = 8'h00;
    wait_n(4);
    in_a = 8'h01;
    wait_n(2);
    wr_a(ADDR_EDGE, 32'h01);
    rd ("collide_edge", 1'b0, ADDR_EDGE, 32'h01);
    wait_n(1);
    chk("collide_irq", 32'(irq_a), 32'h1);
    wr_a(ADDR_EDGE, 32'h01);
    wait_n(1);
    chk("clean_irq", 32'(irq_a), 32'h0);

    wr_a(ADDR_DIR, 32'h04);
    wr_a(ADDR_CLR, 32'h04);
    chk("oe_out", 32'(out_a), 32'h38);
    in_a = 8'h05; wait_n(4);
    in_a = 8'h01; wait_n(4);
    in_a = 8'h05; wait_n(4);
    rd ("oe_no_edge", 1'b0, ADDR_EDGE, 32'h00);
    rd ("oe_data",    1'b0, ADDR_DATA, 32'h01);
    rd ("rd_a6",      1'b0, 3'd6,      32'h0);
    rd ("rd_a7",      1'b0, 3'd7,      32'h0);
    wr_a(3'd6, 32'hFF);
    chk("a6_ignored", 32'(out_a), 32'h38);
    rd ("a6_dir",     1'b0, ADDR_DIR, 32'h04);

    in_b = 8'hF7;
    wait_n(4);
    rd ("any_first",  1'b1, ADDR_EDGE, 32'h08);
    in_b = 8'hFF;
    wait_n(4);
    rd ("any_second", 1'b1, ADDR_EDGE, 32'h08);
    chk("b_irq_masked", 32'(irq_b), 32'h0);

    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out_a), 32'hA5);
    chk("mid_rst_oe",  32'(oe_a),  32'hFF);
    rd ("mid_rst_edge_b", 1'b1, ADDR_EDGE, 32'h0);
    rd ("mid_rst_mask",   1'b0, ADDR_MASK, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_n(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
